// File: rtl/axis_traffic_gen_if.sv
// AXI4-Stream bus shared by the traffic generator and its consumers.
// The package carries the destination type so ports and bus agree on width.
package axis_traffic_gen_pkg;
    typedef logic [3:0] axi_dest_t;
endpackage

interface axi_stream_interface;
    logic                            tvalid;
    logic                            tready;
    logic [63:0]                     tdata;
    logic [7:0]                      tstrb;
    logic [7:0]                      tkeep;
    logic                            tlast;
    logic [7:0]                      tid;
    axis_traffic_gen_pkg::axi_dest_t tdest;
    logic                            tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_traffic_gen.sv
// AXI4-Stream burst traffic generator.
// A run is num_bursts bursts of LEN beats, optionally separated by GAP idle
// cycles. Payload is a deterministic counter pattern derived from DATA_SEED.
// Optional backpressure statistics are compiled in with the macro
// AXIS_TRAFFIC_GEN_STALL_STATS_EN; without it stall_cnt reads as zero.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; run parameters latched on start
// TDATA    | presenting a beat (tvalid high) until it is accepted
// GAPWAIT  | idle cycles between bursts, counted down in gap_q
module axis_traffic_gen #(
    parameter int unsigned ID        = 0,
    parameter int unsigned LEN       = 24,
    parameter int unsigned GAP       = 0,
    parameter logic [63:0] DATA_SEED = 64'hdeadbeef00000000
) (
    input  logic                            CLK,
    input  logic                            RST,
    axi_stream_interface.master             axis,
    input  logic                            start,
    input  axis_traffic_gen_pkg::axi_dest_t dest,
    input  logic [7:0]                      num_bursts,
    output logic                            busy,
    output logic                            done,
    output logic [31:0]                     stall_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_TDATA   = 2'd1;
    localparam logic [1:0] S_GAPWAIT = 2'd2;

    localparam logic [7:0] LAST_BEAT = 8'(LEN - 1);
    // GAPWAIT lasts gap_q+1 cycles, so load GAP-1 to get exactly GAP cycles.
    localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);

    logic [1:0]                      state_q, state_d;
    logic [7:0]                      beat_q, beat_d;
    logic [7:0]                      burst_q, burst_d;
    logic [7:0]                      nb_q, nb_d;
    logic [7:0]                      gap_q, gap_d;
    axis_traffic_gen_pkg::axi_dest_t dest_q, dest_d;
    logic                            done_q, done_d;
    logic                            handshake;
    logic                            run_accept;

    assign handshake  = axis.tvalid && axis.tready;
    assign run_accept = (state_q == S_IDLE) && start;

    // Next-state logic: indices only move on a handshake, which keeps the
    // payload stable while the sink stalls.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        nb_d    = nb_q;
        gap_d   = gap_q;
        dest_d  = dest_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dest_d  = dest;
                    nb_d    = num_bursts;
                    beat_d  = 8'd0;
                    burst_d = 8'd0;
                    if (num_bursts != 8'd0) begin
                        state_d = S_TDATA;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_TDATA: begin
                if (handshake) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 8'd0;
                        burst_d = burst_q + 8'd1;
                        if (burst_q == nb_q - 8'd1) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else if (GAP > 0) begin
                            state_d = S_GAPWAIT;
                            gap_d   = GAP_LOAD;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_GAPWAIT: begin
                if (gap_q == 8'd0) begin
                    state_d = S_TDATA;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and run registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            beat_q  <= 8'd0;
            burst_q <= 8'd0;
            nb_q    <= 8'd0;
            gap_q   <= 8'd0;
            dest_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            nb_q    <= nb_d;
            gap_q   <= gap_d;
            dest_q  <= dest_d;
            done_q  <= done_d;
        end
    end

    assign axis.tvalid = (state_q == S_TDATA);
    assign axis.tlast  = (state_q == S_TDATA) && (beat_q == LAST_BEAT);
    assign axis.tdata  = DATA_SEED + {40'd0, burst_q, 16'd0} + {56'd0, beat_q};
    assign axis.tstrb  = '1;
    assign axis.tkeep  = '1;
    assign axis.tid    = 8'(ID);
    assign axis.tdest  = dest_q;
    assign axis.tuser  = 1'b0;

    assign busy = (state_q == S_TDATA) || (state_q == S_GAPWAIT);
    assign done = done_q;

`ifdef AXIS_TRAFFIC_GEN_STALL_STATS_EN
    logic [31:0] stall_q;

    // Saturating count of cycles the sink held off a valid beat.
    always_ff @(posedge CLK) begin
        if (RST || run_accept) begin
            stall_q <= 32'd0;
        end else if (axis.tvalid && !axis.tready && (stall_q != 32'hffff_ffff)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Self-checking bench for axis_traffic_gen: directed run sequence with
// randomized backpressure and destinations, checked against a beat-stream
// model computed from burst/beat arithmetic.
module tb_axis_traffic_gen;

    localparam int unsigned ID        = 5;
    localparam int unsigned LEN       = 3;
    localparam int unsigned GAP       = 2;
    localparam logic [63:0] DATA_SEED = 64'hdeadbeef00000000;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            start;
    axis_traffic_gen_pkg::axi_dest_t dest;
    logic [7:0]                      num_bursts;
    logic                            busy;
    logic                            done;
    logic [31:0]                     stall_cnt;

    int total = 0;
    int bad   = 0;
    axis_traffic_gen_pkg::axi_dest_t cur_dest;

    axi_stream_interface axis_if ();

    axis_traffic_gen #(
        .ID        (ID),
        .LEN       (LEN),
        .GAP       (GAP),
        .DATA_SEED (DATA_SEED)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .axis       (axis_if),
        .start      (start),
        .dest       (dest),
        .num_bursts (num_bursts),
        .busy       (busy),
        .done       (done),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_stall(input int stalls);
`ifdef AXIS_TRAFFIC_GEN_STALL_STATS_EN
        return 32'(stalls);
`else
        return (stalls == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Called at the negedge just before the edge that samples start.
    // mode 0: always ready, 1: random ready, 2: two stall cycles per beat.
    task automatic monitor_run(input int nb, input int mode, input bit keep_start);
        int k, stalls, idle, cyc, beat_stalls, total_beats;
        bit need_gap, prev_stall;
        logic [63:0] prev_data, exp_data;
        total_beats = nb * int'(LEN);
        k = 0; stalls = 0; idle = 0; cyc = 0; beat_stalls = 0;
        need_gap = 1'b0; prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        chk("first_valid", axis_if.tvalid, 1'b1);
        chk("busy_run", busy, 1'b1);
        chk("tid", axis_if.tid, 64'(ID));
        chk("tkeep", axis_if.tkeep, 8'hff);
        chk("tstrb", axis_if.tstrb, 8'hff);
        chk("tuser", axis_if.tuser, 1'b0);
        if (!keep_start) start = 1'b0;
        while (k < total_beats && cyc < 4000) begin
            case (mode)
                0:       axis_if.tready = 1'b1;
                1:       axis_if.tready = 1'($urandom_range(0, 1));
                default: axis_if.tready = (beat_stalls >= 2);
            endcase
            chk("no_early_done", done, 1'b0);
            if (prev_stall) chk("valid_held", axis_if.tvalid, 1'b1);
            if (axis_if.tvalid) begin
                exp_data = DATA_SEED + (64'(k / int'(LEN)) << 16) + 64'(k % int'(LEN));
                chk("tdata", axis_if.tdata, exp_data);
                chk("tlast", axis_if.tlast, (k % int'(LEN)) == int'(LEN) - 1);
                chk("tdest", axis_if.tdest, cur_dest);
                if (need_gap) begin
                    chk("gap_len", 64'(idle), 64'(GAP));
                    need_gap = 1'b0;
                end
                if (prev_stall) chk("data_held", axis_if.tdata, prev_data);
                if (axis_if.tready) begin
                    k++;
                    beat_stalls = 0;
                    prev_stall  = 1'b0;
                    if ((k % int'(LEN)) == 0 && k < total_beats) begin
                        need_gap = 1'b1;
                        idle     = 0;
                    end
                end else begin
                    stalls++;
                    beat_stalls++;
                    prev_stall = 1'b1;
                    prev_data  = axis_if.tdata;
                end
            end else begin
                chk("busy_gap", busy, 1'b1);
                idle++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("beats_seen", 64'(k), 64'(total_beats));
        chk("done_pulse", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        chk("valid_end", axis_if.tvalid, 1'b0);
        chk("stall_cnt", stall_cnt, exp_stall(stalls));
    endtask

    initial begin
        int k, cyc;
        rst = 1'b1; start = 1'b0; dest = '0; num_bursts = 8'd0;
        axis_if.tready = 1'b0;
        cur_dest = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid", axis_if.tvalid, 1'b0);
        chk("rst_tlast", axis_if.tlast, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_tdest", axis_if.tdest, 4'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single burst, always ready
        cur_dest = 4'($urandom); dest = cur_dest; num_bursts = 8'd1; start = 1'b1;
        monitor_run(1, 0, 1'b0);

        // Two bursts with gap, always ready
        cur_dest = 4'($urandom); dest = cur_dest; num_bursts = 8'd2; start = 1'b1;
        monitor_run(2, 0, 1'b0);

        // Random backpressure, several run lengths
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            cur_dest = 4'($urandom); dest = cur_dest;
            num_bursts = 8'($urandom_range(1, 4)); start = 1'b1;
            monitor_run(int'(num_bursts), 1, 1'b0);
        end

        // Fixed 1,0,0,1 style stall pattern: two stall cycles per beat
        cur_dest = 4'($urandom); dest = cur_dest; num_bursts = 8'd2; start = 1'b1;
        monitor_run(2, 2, 1'b0);

        // Zero-burst run: done only
        @(negedge clk);
        num_bursts = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("nb0_done", done, 1'b1);
        chk("nb0_busy", busy, 1'b0);
        chk("nb0_valid", axis_if.tvalid, 1'b0);
        @(negedge clk);
        chk("nb0_done_once", done, 1'b0);
        chk("nb0_valid2", axis_if.tvalid, 1'b0);

        // Reset mid-burst at beat 2
        axis_if.tready = 1'b1;
        cur_dest = 4'($urandom); dest = cur_dest; num_bursts = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; cyc = 0;
        while (k < 2 && cyc < 100) begin
            if (axis_if.tvalid) k++;
            @(negedge clk);
            cyc++;
        end
        chk("mid_beat2", axis_if.tdata, DATA_SEED + 64'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", axis_if.tvalid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_tlast", axis_if.tlast, 1'b0);
        chk("mid_rst_stall", stall_cnt, 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_done", done, 1'b0);
            chk("mid_idle_valid", axis_if.tvalid, 1'b0);
        end
        cur_dest = 4'($urandom); dest = cur_dest; num_bursts = 8'd1; start = 1'b1;
        monitor_run(1, 1, 1'b0);

        // Start held across reset release
        rst = 1'b1; start = 1'b1; num_bursts = 8'd1;
        cur_dest = 4'($urandom); dest = cur_dest;
        @(negedge clk);
        chk("hold_rst_valid", axis_if.tvalid, 1'b0);
        rst = 1'b0;
        monitor_run(1, 0, 1'b0);

        // Start held continuously: back-to-back runs
        @(negedge clk);
        cur_dest = 4'($urandom); dest = cur_dest; num_bursts = 8'd2; start = 1'b1;
        monitor_run(2, 0, 1'b1);
        monitor_run(2, 1, 1'b0);
        @(negedge clk);
        chk("after_runs_valid", axis_if.tvalid, 1'b0);
        chk("after_runs_busy", busy, 1'b0);
        chk("after_runs_done", done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
